// File: rtl/avalon_sha3_master.sv
// -----------------------------------------------------------------------------
// avalon_sha3_master
//   Avalon-MM master that feeds the SHA3 slave without software involvement.
//   For each accepted command it writes one message block from the input word
//   stream into the core, writes the control word, and polls status until the
//   core is ready. After the final block it reads the digest out to a word stream.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_first, cmd_last            block is first (init) / last (digest follows)
//   in_valid/in_ready/in_data      message word stream
//   out_valid/out_ready/out_data   digest word stream, word 0 first
//   out_last                       marks the final digest word
//   busy                           sequencer not idle
//   timeout                        sticky; status never became ready
//   avm_*                          Avalon-MM master port (8-bit address, 32-bit data)
// -----------------------------------------------------------------------------
module avalon_sha3_master #(
  parameter int          BLOCK_WORDS  = 18,
  parameter int          DIGEST_WORDS = 16,
  parameter logic [7:0]  ADDR_CTRL    = 8'h08,
  parameter logic [7:0]  ADDR_STATUS  = 8'h09,
  parameter logic [7:0]  ADDR_BLOCK   = 8'h10,
  parameter logic [7:0]  ADDR_DIGEST  = 8'h40,
  parameter logic [31:0] CTRL_INIT    = 32'h1,
  parameter logic [31:0] CTRL_NEXT    = 32'h2,
  parameter int          READY_BIT    = 0,
  parameter int          POLL_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_first,
  input  logic        cmd_last,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        timeout,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int CNT_W  = $clog2(BLOCK_WORDS + 1);
  localparam int IDX_W  = $clog2(DIGEST_WORDS + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BLK, S_WR_CTRL, S_POLL, S_RD_DIG, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  word_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [POLL_W-1:0] poll_cnt;
  logic              first_q, last_q;

  // Strobes are registered, so a transfer is "pending" exactly while a strobe
  // is high. Dropping the strobe on completion and only issuing from an idle
  // bus guarantees at least one idle cycle between transfers.
  logic bus_pending, xfer_done, status_ready;
  logic blk_last, dig_last, poll_hit;
  logic issue_wr, issue_rd;
  logic [7:0]  issue_addr;
  logic [31:0] issue_data;

  assign bus_pending  = avm_read | avm_write;
  assign xfer_done    = bus_pending & ~avm_waitrequest;
  assign status_ready = avm_readdata[READY_BIT];
  assign blk_last     = (word_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign dig_last     = (dig_idx == IDX_W'(DIGEST_WORDS - 1));
  // True when the read completing now is the POLL_LIMIT-th one.
  assign poll_hit     = (poll_cnt == POLL_W'(POLL_LIMIT - 1));
  assign busy         = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (cmd_valid) state_nxt = S_WR_BLK;
      S_WR_BLK:  if (xfer_done && blk_last) state_nxt = S_WR_CTRL;
      S_WR_CTRL: if (xfer_done) state_nxt = S_POLL;
      S_POLL: begin
        if (xfer_done) begin
          if (status_ready) state_nxt = last_q ? S_RD_DIG : S_IDLE;
          else if (poll_hit) state_nxt = S_IDLE;
        end
      end
      S_RD_DIG:  if (xfer_done) state_nxt = S_OUT;
      S_OUT:     if (out_ready) state_nxt = dig_last ? S_IDLE : S_RD_DIG;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / transfer-issue logic
  always_comb begin
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    issue_addr = avm_address;
    issue_data = avm_writedata;
    unique case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_WR_BLK: begin
        in_ready = ~bus_pending;
        if (in_valid && !bus_pending) begin
          issue_wr   = 1'b1;
          issue_addr = ADDR_BLOCK + 8'(word_cnt);
          issue_data = in_data;
        end
      end
      S_WR_CTRL: begin
        if (!bus_pending) begin
          issue_wr   = 1'b1;
          issue_addr = ADDR_CTRL;
          issue_data = first_q ? CTRL_INIT : CTRL_NEXT;
        end
      end
      S_POLL: begin
        if (!bus_pending) begin
          issue_rd   = 1'b1;
          issue_addr = ADDR_STATUS;
        end
      end
      S_RD_DIG: begin
        if (!bus_pending) begin
          issue_rd   = 1'b1;
          issue_addr = ADDR_DIGEST + 8'(dig_idx);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = dig_last;
      end
      default: ;
    endcase
  end

  // Datapath: bus registers, counters, captured digest word, sticky timeout.
  // The async reset drops any in-flight strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      word_cnt      <= '0;
      dig_idx       <= '0;
      poll_cnt      <= '0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      timeout       <= 1'b0;
      out_data      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (xfer_done) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end else if (issue_wr || issue_rd) begin
        avm_read    <= issue_rd;
        avm_write   <= issue_wr;
        avm_address <= issue_addr;
        if (issue_wr) avm_writedata <= issue_data;
      end

      if (cmd_valid && cmd_ready) begin
        first_q  <= cmd_first;
        last_q   <= cmd_last;
        timeout  <= 1'b0;
        word_cnt <= '0;
        poll_cnt <= '0;
        dig_idx  <= '0;
      end

      if (state == S_WR_BLK && xfer_done) word_cnt <= word_cnt + CNT_W'(1);

      if (state == S_POLL && xfer_done) begin
        poll_cnt <= poll_cnt + POLL_W'(1);
        if (!status_ready && poll_hit) timeout <= 1'b1;
      end

      if (state == S_RD_DIG && xfer_done) out_data <= avm_readdata;
      if (state == S_OUT && out_ready && !dig_last) dig_idx <= dig_idx + IDX_W'(1);
    end
  end

endmodule
